hnf_link_tx_crd_arb: RTL and testbench
======================================

HNF_LINK_TX_CRD_ARB -- requirements
Module: hnf_link_tx_crd_arb

Interface
REQ-001 Parameter NUM_SRC, default 2: number of flit sources arbitrated onto the channel; range 1..8.
REQ-002 Parameter FLIT_WIDTH, default `CHIE_REQ_FLIT_WIDTH: width of the packed flit.
REQ-003 Parameter MAX_CRD, default 15: maximum L-credits held; range 1..15.
REQ-004 Parameter CRD_CNT_WIDTH, default 4: credit counter width; SHALL be at least clog2(MAX_CRD+1).
REQ-005 Parameter FIXED_PRIO, default 0: 1 selects fixed priority (lowest index wins); 0 selects round-robin.
REQ-006 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-007 clk  in  1  clock; all state on rising edge.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 src_valid  in  NUM_SRC  per-source send request.
REQ-010 src_flit  in  NUM_SRC*FLIT_WIDTH  packed flits; source i occupies bits [i*FLIT_WIDTH +: FLIT_WIDTH].
REQ-011 src_won  out  NUM_SRC  one-hot grant; source i's flit is accepted this cycle.
REQ-012 lcrdv  in  1  link credit grant from the link.
REQ-013 lcrd_return_flit  in  FLIT_WIDTH  static credit-return flit (LCrdReturn opcode, IDs filled in).
REQ-014 deact_req  in  1  level request to deactivate the link and return credits.
REQ-015 deact_done  out  1  all credits returned; channel is stopped.
REQ-016 txflitv / txflit / txflitpend  out  1 / FLIT_WIDTH / 1  flit to the link.
REQ-017 crd_cnt  out  CRD_CNT_WIDTH  current credit count.
REQ-018 crd_ovf_err  out  1  sticky error: credit received while at MAX_CRD.

Function
REQ-019 Credit available (crd_av) = lcrdv OR crd_cnt != 0; a credit arriving this cycle is usable this cycle.
REQ-020 In RUN with crd_av = 1, exactly one valid source SHALL be granted; src_won is zero when crd_av = 0, in any other state, or when no source is valid.
REQ-021 Round-robin: the pointer advances to the winner index + 1 (mod NUM_SRC) only on a grant; search starts at the pointer.
REQ-022 The grant is combinational; txflit is the granted flit and txflitv = 1 on the next clock edge (1-cycle latency); txflit holds its value when txflitv = 0.
REQ-023 Counter next-state: lcrdv only -> +1; send only -> -1; both -> hold; neither -> hold.
REQ-024 If lcrdv arrives while crd_cnt = MAX_CRD with no send, the counter saturates and crd_ovf_err is set until reset.
REQ-025 FSM states are RUN, RETURN and STOP; reset enters RUN.
REQ-026 RUN -> RETURN when deact_req = 1; any grant in that same cycle is suppressed.
REQ-027 In RETURN, each cycle with crd_av = 1 SHALL send lcrd_return_flit (txflitv next cycle) and consume one credit, with the same simultaneous lcrdv rules as REQ-023.
REQ-028 RETURN -> STOP when crd_cnt = 0, lcrdv = 0 and no return is in flight; in STOP, deact_done = 1 and txflitpend = 0.
REQ-029 In STOP, lcrdv increments the counter but sends nothing.
REQ-030 STOP -> RUN when deact_req = 0; deact_done deasserts in the same cycle.
REQ-031 A deact_req drop during RETURN returns the FSM to RUN next cycle.
REQ-032 txflitpend = 1 in RUN and RETURN.

Reset
REQ-033 Reset values: txflitv = 0, txflit = 0, crd_cnt = 0, rr pointer = 0, crd_ovf_err = 0, FSM = RUN, deact_done = 0; txflitpend = 1 after reset release.

Structure
REQ-034 FSM state encodings and the MAX_CRD/CRD_CNT_WIDTH defaults belong in hnf_defines.v / hnf_param.v; flit field ranges come from chie_defines.v.
REQ-035 The arbiter is one sub-module, hnf_rr_arb (NUM_SRC, FIXED_PRIO), producing a one-hot grant and the pointer update; all else is in the top module.

Verification
REQ-036 NUM_SRC=2, no credits, src_valid=2'b11 for 3 cycles -> src_won=0, txflitv=0; then lcrdv pulse -> one grant the same cycle, txflitv=1 next cycle, crd_cnt stays 0.
REQ-037 5 lcrdv pulses, then src_valid=2'b11 held, round-robin -> grants alternate 01,10,01,10,01; crd_cnt 5->0; no grant thereafter.
REQ-038 crd_cnt=15 (MAX_CRD), lcrdv with no send -> crd_cnt stays 15, crd_ovf_err=1 and sticky; lcrdv with a send -> crd_cnt stays 15 and no error is raised.
REQ-039 crd_cnt=3, deact_req=1 with src_valid active -> no src_won; three lcrd_return_flit sends on consecutive cycles; deact_done=1 once crd_cnt=0; deact_req=0 -> RUN.
REQ-040 rst_n asserted mid-RETURN with crd_cnt=2 -> txflitv=0, crd_cnt=0, FSM=RUN asynchronously.
REQ-041 FIXED_PRIO=1, src_valid=3'b110 held with ample credits -> src_won=3'b010 every cycle.

Source files
------------

// File: rtl/hnf_link_tx_crd_arb_pkg.sv
// Shared constants and FSM encoding for the HN-F link TX credit arbiter.
package hnf_link_tx_crd_arb_pkg;

  localparam int CHIE_REQ_FLIT_WIDTH = 151;
  localparam int HNF_MAX_CRD         = 15;
  localparam int HNF_CRD_CNT_WIDTH   = 4;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_RETURN = 2'd1,
    ST_STOP   = 2'd2
  } link_st_t;

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hnf_link_tx_crd_arb_rr_arb.sv
// Source arbiter: one-hot grant, round-robin or fixed priority, owns the rr pointer.
module hnf_link_tx_crd_arb_rr_arb
  import hnf_link_tx_crd_arb_pkg::*;
#(
  parameter int NUM_SRC    = 2,
  parameter int FIXED_PRIO = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] req,
  input  logic               en,
  output logic [NUM_SRC-1:0] gnt
);

  localparam int PTR_W = ptr_width(NUM_SRC);

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] win;
  logic [PTR_W-1:0] cand;
  logic             found;
  int               idx;

  // Search starts at the pointer (or at 0 for fixed priority); first requester wins.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    win   = '0;
    cand  = '0;
    idx   = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
      idx  = (FIXED_PRIO != 0) ? i : (int'(ptr) + i) % NUM_SRC;
      cand = PTR_W'(idx);
      if (en && !found && req[cand]) begin
        gnt[cand] = 1'b1;
        found     = 1'b1;
        win       = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (win == PTR_W'(NUM_SRC - 1)) ? '0 : win + PTR_W'(1);
    end
  end

endmodule

// File: rtl/hnf_link_tx_crd_arb.sv
// Link TX channel: arbitrates flit sources against L-credits and handles credit return on deactivation.
module hnf_link_tx_crd_arb
  import hnf_link_tx_crd_arb_pkg::*;
#(
  parameter int NUM_SRC       = 2,
  parameter int FLIT_WIDTH    = CHIE_REQ_FLIT_WIDTH,
  parameter int MAX_CRD       = HNF_MAX_CRD,
  parameter int CRD_CNT_WIDTH = HNF_CRD_CNT_WIDTH,
  parameter int FIXED_PRIO    = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_SRC-1:0]            src_valid,
  input  logic [NUM_SRC*FLIT_WIDTH-1:0] src_flit,
  output logic [NUM_SRC-1:0]            src_won,
  input  logic                          lcrdv,
  input  logic [FLIT_WIDTH-1:0]         lcrd_return_flit,
  input  logic                          deact_req,
  output logic                          deact_done,
  output logic                          txflitv,
  output logic [FLIT_WIDTH-1:0]         txflit,
  output logic                          txflitpend,
  output logic [CRD_CNT_WIDTH-1:0]      crd_cnt,
  output logic                          crd_ovf_err
);

  link_st_t                state, state_nxt;
  logic                    crd_av;
  logic                    arb_en;
  logic                    grant_any;
  logic                    ret_send;
  logic                    send;
  logic [FLIT_WIDTH-1:0]   sel_flit;

  // A credit arriving this cycle can be spent this cycle.
  assign crd_av    = lcrdv || (crd_cnt != '0);
  assign arb_en    = (state == ST_RUN) && !deact_req && crd_av;
  assign grant_any = |src_won;
  assign ret_send  = (state == ST_RETURN) && crd_av;
  assign send      = grant_any || ret_send;

  hnf_link_tx_crd_arb_rr_arb #(
    .NUM_SRC   (NUM_SRC),
    .FIXED_PRIO(FIXED_PRIO)
  ) u_arb (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (src_valid),
    .en   (arb_en),
    .gnt  (src_won)
  );

  always_comb begin
    sel_flit = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_won[i]) sel_flit = src_flit[i*FLIT_WIDTH +: FLIT_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txflitv <= 1'b0;
      txflit  <= '0;
    end else begin
      txflitv <= send;
      if (send) txflit <= grant_any ? sel_flit : lcrd_return_flit;
    end
  end

  // Simultaneous credit arrival and send cancel out; overflow saturates and latches an error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crd_cnt     <= '0;
      crd_ovf_err <= 1'b0;
    end else if (lcrdv && !send) begin
      if (crd_cnt == CRD_CNT_WIDTH'(MAX_CRD)) crd_ovf_err <= 1'b1;
      else                                    crd_cnt     <= crd_cnt + CRD_CNT_WIDTH'(1);
    end else if (send && !lcrdv) begin
      crd_cnt <= crd_cnt - CRD_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= state_nxt;
  end

  // STOP is reached only once the last return flit has left the register.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:    if (deact_req) state_nxt = ST_RETURN;
      ST_RETURN: begin
        if (!deact_req)                                  state_nxt = ST_RUN;
        else if ((crd_cnt == '0) && !lcrdv && !txflitv) state_nxt = ST_STOP;
      end
      ST_STOP:   if (!deact_req) state_nxt = ST_RUN;
      default:   state_nxt = ST_RUN;
    endcase
  end

  assign deact_done = (state == ST_STOP) && deact_req;
  assign txflitpend = (state != ST_STOP);

endmodule

// File: tb/tb_hnf_link_tx_crd_arb.sv
// Directed scoreboard bench for hnf_link_tx_crd_arb (round-robin and fixed-priority instances).
module tb_hnf_link_tx_crd_arb;

  localparam int FW = 16;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    src_valid = '0;
  logic [2*FW-1:0] src_flit = {16'hB111, 16'hA000};
  logic [1:0]    src_won;
  logic          lcrdv = 1'b0;
  logic [FW-1:0] lcrd_return_flit = 16'hC0DE;
  logic          deact_req = 1'b0;
  logic          deact_done, txflitv, txflitpend, crd_ovf_err;
  logic [FW-1:0] txflit;
  logic [3:0]    crd_cnt;

  logic [2:0]    fp_valid = '0;
  logic [3*FW-1:0] fp_flit = {16'h3333, 16'h2222, 16'h1111};
  logic [2:0]    fp_won;
  logic          fp_lcrdv = 1'b0;
  logic          fp_deact_done, fp_txflitv, fp_txflitpend, fp_ovf;
  logic [FW-1:0] fp_txflit;
  logic [3:0]    fp_crd_cnt;

  int total = 0;
  int bad   = 0;
  logic [FW-1:0] exp_q[$];

  always #5 clk = ~clk;

  hnf_link_tx_crd_arb #(
    .NUM_SRC(2), .FLIT_WIDTH(FW), .MAX_CRD(15), .CRD_CNT_WIDTH(4), .FIXED_PRIO(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .src_valid(src_valid), .src_flit(src_flit), .src_won(src_won),
    .lcrdv(lcrdv), .lcrd_return_flit(lcrd_return_flit), .deact_req(deact_req),
    .deact_done(deact_done), .txflitv(txflitv), .txflit(txflit), .txflitpend(txflitpend),
    .crd_cnt(crd_cnt), .crd_ovf_err(crd_ovf_err)
  );

  hnf_link_tx_crd_arb #(
    .NUM_SRC(3), .FLIT_WIDTH(FW), .MAX_CRD(15), .CRD_CNT_WIDTH(4), .FIXED_PRIO(1)
  ) dut_fp (
    .clk(clk), .rst_n(rst_n), .src_valid(fp_valid), .src_flit(fp_flit), .src_won(fp_won),
    .lcrdv(fp_lcrdv), .lcrd_return_flit(lcrd_return_flit), .deact_req(1'b0),
    .deact_done(fp_deact_done), .txflitv(fp_txflitv), .txflit(fp_txflit),
    .txflitpend(fp_txflitpend), .crd_cnt(fp_crd_cnt), .crd_ovf_err(fp_ovf)
  );

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] v, input logic l, input logic d);
    @(negedge clk);
    src_valid = v;
    lcrdv     = l;
    deact_req = d;
    #1;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0; src_valid = '0; lcrdv = 1'b0; deact_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic loadCredits(input int n);
    for (int i = 0; i < n; i++) applyStimulus(2'b00, 1'b1, 1'b0);
    applyStimulus(2'b00, 1'b0, 1'b0);
    checkOutput("crd_loaded", 32'(crd_cnt), 32'(n));
  endtask

  // Monitor: every flit the DUT presents must match the oldest expected flit.
  always begin
    logic [FW-1:0] e;
    @(posedge clk);
    #1;
    if (rst_n && txflitv) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("[TB] FAIL sb_extra: got txflit %0h expected no flit at %0t", txflit, $time);
      end else begin
        e = exp_q.pop_front();
        if (txflit !== e) begin
          bad++;
          $display("[TB] FAIL sb_flit: got %0h expected %0h at %0t", txflit, e, $time);
        end
      end
    end
  end

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_txflitv", 32'(txflitv), 32'd0);
    checkOutput("rst_txflit", 32'(txflit), 32'd0);
    checkOutput("rst_crd_cnt", 32'(crd_cnt), 32'd0);
    checkOutput("rst_ovf", 32'(crd_ovf_err), 32'd0);
    checkOutput("rst_deact_done", 32'(deact_done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(2'b00, 1'b0, 1'b0);
    checkOutput("pend_after_rst", 32'(txflitpend), 32'd1);

    // No credits: no grant; a single lcrdv is usable the same cycle
    for (int i = 0; i < 3; i++) begin
      applyStimulus(2'b11, 1'b0, 1'b0);
      checkOutput("nocrd_won", 32'(src_won), 32'd0);
    end
    applyStimulus(2'b11, 1'b1, 1'b0);
    checkOutput("lcrdv_won", 32'(src_won), 32'b01);
    exp_q.push_back(16'hA000);
    applyStimulus(2'b00, 1'b0, 1'b0);
    checkOutput("lcrdv_crd_hold", 32'(crd_cnt), 32'd0);

    // Round-robin over 5 credits
    doReset();
    loadCredits(5);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(2'b11, 1'b0, 1'b0);
      checkOutput("rr_won", 32'(src_won), (k % 2 == 0) ? 32'b01 : 32'b10);
      checkOutput("rr_crd", 32'(crd_cnt), 32'(5 - k));
      exp_q.push_back((k % 2 == 0) ? 16'hA000 : 16'hB111);
    end
    for (int k = 0; k < 2; k++) begin
      applyStimulus(2'b11, 1'b0, 1'b0);
      checkOutput("rr_exhausted_won", 32'(src_won), 32'd0);
      checkOutput("rr_exhausted_crd", 32'(crd_cnt), 32'd0);
    end

    // Saturation and sticky overflow
    doReset();
    loadCredits(15);
    checkOutput("sat_ovf_pre", 32'(crd_ovf_err), 32'd0);
    applyStimulus(2'b00, 1'b1, 1'b0);
    applyStimulus(2'b00, 1'b0, 1'b0);
    checkOutput("sat_crd", 32'(crd_cnt), 32'd15);
    checkOutput("sat_ovf", 32'(crd_ovf_err), 32'd1);
    applyStimulus(2'b00, 1'b0, 1'b0);
    checkOutput("sat_ovf_sticky", 32'(crd_ovf_err), 32'd1);
    doReset();
    loadCredits(15);
    applyStimulus(2'b01, 1'b1, 1'b0);
    checkOutput("sat_send_won", 32'(src_won), 32'b01);
    exp_q.push_back(16'hA000);
    applyStimulus(2'b00, 1'b0, 1'b0);
    checkOutput("sat_send_crd", 32'(crd_cnt), 32'd15);
    checkOutput("sat_send_ovf", 32'(crd_ovf_err), 32'd0);

    // Deactivation: return 3 credits, stop, reactivate
    doReset();
    loadCredits(3);
    applyStimulus(2'b11, 1'b0, 1'b1);
    checkOutput("deact_suppress", 32'(src_won), 32'd0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(2'b11, 1'b0, 1'b1);
      checkOutput("ret_won", 32'(src_won), 32'd0);
      checkOutput("ret_crd", 32'(crd_cnt), 32'(3 - k));
      exp_q.push_back(16'hC0DE);
    end
    applyStimulus(2'b11, 1'b0, 1'b1);
    checkOutput("ret_drain_done", 32'(deact_done), 32'd0);
    applyStimulus(2'b11, 1'b0, 1'b1);
    applyStimulus(2'b11, 1'b0, 1'b1);
    checkOutput("stop_done", 32'(deact_done), 32'd1);
    checkOutput("stop_pend", 32'(txflitpend), 32'd0);
    applyStimulus(2'b11, 1'b1, 1'b1);
    checkOutput("stop_won", 32'(src_won), 32'd0);
    applyStimulus(2'b11, 1'b0, 1'b0);
    checkOutput("stop_crd_inc", 32'(crd_cnt), 32'd1);
    checkOutput("reactivate_done", 32'(deact_done), 32'd0);
    checkOutput("reactivate_won_stop", 32'(src_won), 32'd0);
    applyStimulus(2'b01, 1'b0, 1'b0);
    checkOutput("run_again_won", 32'(src_won), 32'b01);
    exp_q.push_back(16'hA000);
    applyStimulus(2'b00, 1'b0, 1'b0);

    // Async reset in the middle of RETURN
    doReset();
    loadCredits(4);
    applyStimulus(2'b00, 1'b0, 1'b1);
    applyStimulus(2'b00, 1'b0, 1'b1);
    exp_q.push_back(16'hC0DE);
    applyStimulus(2'b00, 1'b0, 1'b1);
    exp_q.push_back(16'hC0DE);
    @(negedge clk);
    checkOutput("midret_crd", 32'(crd_cnt), 32'd2);
    rst_n = 1'b0; deact_req = 1'b0;
    #1;
    checkOutput("async_txflitv", 32'(txflitv), 32'd0);
    checkOutput("async_crd", 32'(crd_cnt), 32'd0);
    checkOutput("async_pend", 32'(txflitpend), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(2'b01, 1'b1, 1'b0);
    checkOutput("async_run_won", 32'(src_won), 32'b01);
    exp_q.push_back(16'hA000);
    applyStimulus(2'b00, 1'b0, 1'b0);

    // Fixed priority instance
    fp_valid = 3'b110;
    fp_lcrdv = 1'b1;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(2'b00, 1'b0, 1'b0);
      checkOutput("fp_won", 32'(fp_won), 32'b010);
    end
    fp_valid = '0;
    fp_lcrdv = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
